// File: rtl/load_data_unit_pkg.sv
// load_data_unit_pkg: shared load/store control codes, bus size encodings and size decode
package load_data_unit_pkg;

    localparam logic [5:0] LB_CONTROL  = 6'b100000;
    localparam logic [5:0] LH_CONTROL  = 6'b100001;
    localparam logic [5:0] LW_CONTROL  = 6'b100011;
    localparam logic [5:0] LBU_CONTROL = 6'b100100;
    localparam logic [5:0] LHU_CONTROL = 6'b100101;
    localparam logic [5:0] SB_CONTROL  = 6'b101000;
    localparam logic [5:0] SH_CONTROL  = 6'b101001;
    localparam logic [5:0] SW_CONTROL  = 6'b101011;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic [1:0] size_of(input logic [5:0] ctl);
        return (ctl == LW_CONTROL || ctl == SW_CONTROL) ? SIZE_W :
               (ctl == LH_CONTROL || ctl == LHU_CONTROL || ctl == SH_CONTROL) ? SIZE_H : SIZE_B;
    endfunction

endpackage

// File: rtl/load_data_unit_extend.sv
// load_extend: selects the addressed byte/halfword of a raw word and sign/zero-extends it
module load_extend
    import load_data_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [5:0]  alucontrolM,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    // byte lane by offset, halfword lane by offset[1], then extend per load type
    always_comb begin
        b      = rdata[{off, 3'b000} +: 8];
        h      = off[1] ? rdata[31:16] : rdata[15:0];
        result = (alucontrolM == LB_CONTROL)  ? {{24{b[7]}}, b} :
                 (alucontrolM == LBU_CONTROL) ? {24'd0, b} :
                 (alucontrolM == LH_CONTROL)  ? {{16{h[15]}}, h} :
                 (alucontrolM == LHU_CONTROL) ? {16'd0, h} : rdata;
    end

endmodule

// File: rtl/load_data_unit.sv
// load_data_unit: M-stage load controller for the SRAM-like data port with extraction and AdEL
module load_data_unit
    import load_data_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic [5:0]  alucontrolM,
    input  logic [31:0] aluoutM,
    input  logic        flushM,
    input  logic        stallext,
    output logic        data_req,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_KILL, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] readdata_q;
    logic [31:0] ext_d;
    logic        is_h, is_w, go, idle;

    load_extend u_ext (
        .rdata       (data_rdata),
        .off         (aluoutM[1:0]),
        .alucontrolM (alucontrolM),
        .result      (ext_d)
    );

    // alignment check and request/stall handshake; address and size come straight from M-stage regs
    always_comb begin
        is_h      = (alucontrolM == LH_CONTROL) || (alucontrolM == LHU_CONTROL);
        is_w      = (alucontrolM == LW_CONTROL);
        adelM     = memreadM & ((is_h & aluoutM[0]) | (is_w & (aluoutM[1] | aluoutM[0])));
        go        = memreadM & ~adelM & ~flushM;
        idle      = (state_q == S_IDLE);
        data_req  = (idle & go) | (state_q == S_REQ);
        stallM    = (idle & go) | (state_q == S_REQ) | (state_q == S_WAIT) | (state_q == S_KILL);
        data_size = size_of(alucontrolM);
        data_addr = aluoutM;
        readdataM = readdata_q;
    end

    // transaction FSM; result is latched only when data returns unflushed in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            readdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: if (go) state_q <= data_addr_ok ? S_WAIT : S_REQ;
                S_REQ:  state_q <= data_addr_ok ? S_WAIT : flushM ? S_IDLE : S_REQ;
                S_WAIT: begin
                    if (data_data_ok) state_q <= flushM ? S_IDLE : S_DONE;
                    else if (flushM) state_q <= S_KILL;
                    if (data_data_ok && !flushM) readdata_q <= ext_d;
                end
                S_KILL: if (data_data_ok) state_q <= S_IDLE;
                S_DONE: if (!stallext || flushM) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_data_unit.sv
// tb_load_data_unit: directed checks of load extraction, AdEL, backpressure, flush and reset
module tb_load_data_unit;
    import load_data_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, memreadM, flushM, stallext, data_addr_ok, data_data_ok;
    logic [5:0]  alucontrolM;
    logic [31:0] aluoutM, data_rdata, data_addr, readdataM;
    logic [1:0]  data_size;
    logic        data_req, stallM, adelM;
    int          n_vec = 0;
    int          n_err = 0;
    int          req_cnt;

    load_data_unit dut (
        .clk(clk), .rst(rst), .memreadM(memreadM), .alucontrolM(alucontrolM),
        .aluoutM(aluoutM), .flushM(flushM), .stallext(stallext),
        .data_req(data_req), .data_size(data_size), .data_addr(data_addr),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .readdataM(readdataM), .stallM(stallM), .adelM(adelM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [5:0] ctl, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [1:0] sz, input logic [31:0] exp);
        step(); memreadM = 1; alucontrolM = ctl; aluoutM = addr; data_addr_ok = 1; #1;
        chk({tag, "_req"}, {31'd0, data_req}, 1);
        chk({tag, "_size"}, {30'd0, data_size}, {30'd0, sz});
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_stall0"}, {31'd0, stallM}, 1);
        step(); data_addr_ok = 0; data_data_ok = 1; data_rdata = rd; #1;
        chk({tag, "_stall1"}, {31'd0, stallM}, 1);
        chk({tag, "_req1"}, {31'd0, data_req}, 0);
        step(); data_data_ok = 0; data_rdata = 32'h0; #1;
        chk({tag, "_stall2"}, {31'd0, stallM}, 0);
        chk({tag, "_data"}, readdataM, exp);
        step(); memreadM = 0; #1;
        chk({tag, "_idle"}, {31'd0, stallM}, 0);
    endtask

    initial begin
        rst = 1; memreadM = 0; alucontrolM = LW_CONTROL; aluoutM = 32'h0; flushM = 0;
        stallext = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
        step(); step(); #1;
        chk("rst_data", readdataM, 32'h0);
        step(); rst = 0; #1;
        chk("rst_req", {31'd0, data_req}, 0);
        chk("rst_stall", {31'd0, stallM}, 0);
        chk("rst_adel", {31'd0, adelM}, 0);

        do_load("lb",  LB_CONTROL,  32'h1003, 32'h80AB_CD12, SIZE_B, 32'hFFFF_FF80);
        do_load("lbu", LBU_CONTROL, 32'h1002, 32'h80AB_CD12, SIZE_B, 32'h0000_00AB);
        do_load("lhu", LHU_CONTROL, 32'h1002, 32'h80AB_CD12, SIZE_H, 32'h0000_80AB);
        do_load("lh",  LH_CONTROL,  32'h1000, 32'h0000_8001, SIZE_H, 32'hFFFF_8001);

        step(); memreadM = 1; alucontrolM = LW_CONTROL; aluoutM = 32'h1006; data_addr_ok = 1; #1;
        chk("lw_mis_adel", {31'd0, adelM}, 1);
        chk("lw_mis_req", {31'd0, data_req}, 0);
        chk("lw_mis_stall", {31'd0, stallM}, 0);
        step(); alucontrolM = LH_CONTROL; aluoutM = 32'h1001; #1;
        chk("lh_mis_adel", {31'd0, adelM}, 1);
        chk("lh_mis_req", {31'd0, data_req}, 0);
        chk("lh_mis_stall", {31'd0, stallM}, 0);
        step(); memreadM = 0; data_addr_ok = 0; #1;
        chk("mis_after_req", {31'd0, data_req}, 0);
        chk("mis_after_data", readdataM, 32'hFFFF_8001);

        req_cnt = 0;
        step(); memreadM = 1; alucontrolM = LW_CONTROL; aluoutM = 32'h1008; stallext = 1; #1;
        if (data_req) req_cnt++;
        chk("bp_addr0", data_addr, 32'h1008);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            if (data_req) req_cnt++;
            chk("bp_addr_hold", data_addr, 32'h1008);
        end
        step(); data_addr_ok = 1; #1;
        if (data_req) req_cnt++;
        chk("bp_size", {30'd0, data_size}, {30'd0, SIZE_W});
        step(); data_addr_ok = 0; #1;
        if (data_req) req_cnt++;
        chk("bp_wait_stall", {31'd0, stallM}, 1);
        step(); data_data_ok = 1; data_rdata = 32'h1234_5678; #1;
        if (data_req) req_cnt++;
        step(); data_data_ok = 0; data_rdata = 32'h0; #1;
        if (data_req) req_cnt++;
        chk("bp_done1_stall", {31'd0, stallM}, 0);
        chk("bp_done1_data", readdataM, 32'h1234_5678);
        step(); #1;
        if (data_req) req_cnt++;
        chk("bp_done2_data", readdataM, 32'h1234_5678);
        step(); stallext = 0; #1;
        if (data_req) req_cnt++;
        chk("bp_done3_data", readdataM, 32'h1234_5678);
        chk("bp_req_cycles", req_cnt, 4);
        step(); memreadM = 0; #1;
        chk("bp_idle_stall", {31'd0, stallM}, 0);

        step(); memreadM = 1; alucontrolM = LW_CONTROL; aluoutM = 32'h100C; data_addr_ok = 1; #1;
        chk("fl_req", {31'd0, data_req}, 1);
        step(); data_addr_ok = 0; flushM = 1; #1;
        chk("fl_wait_stall", {31'd0, stallM}, 1);
        step(); flushM = 0; memreadM = 0; #1;
        chk("fl_kill_stall", {31'd0, stallM}, 1);
        step(); data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
        chk("fl_kill_stall2", {31'd0, stallM}, 1);
        step(); data_data_ok = 0; data_rdata = 32'h0; #1;
        chk("fl_idle_stall", {31'd0, stallM}, 0);
        chk("fl_data_kept", readdataM, 32'h1234_5678);
        do_load("lw_after", LW_CONTROL, 32'h1010, 32'hCAFE_F00D, SIZE_W, 32'hCAFE_F00D);

        step(); memreadM = 1; alucontrolM = LW_CONTROL; aluoutM = 32'h1014; data_addr_ok = 1; #1;
        step(); data_addr_ok = 0; rst = 1; #1;
        step(); rst = 0; memreadM = 0; data_data_ok = 1; data_rdata = 32'h5555_5555; #1;
        chk("mr_stall", {31'd0, stallM}, 0);
        chk("mr_req", {31'd0, data_req}, 0);
        chk("mr_data", readdataM, 32'h0);
        step(); data_data_ok = 0; #1;
        chk("mr_stray_ignored", readdataM, 32'h0);
        chk("mr_stall2", {31'd0, stallM}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
